// File: rtl/pkt_encoder.sv
// Packet encoder: round-robin picks a source with a complete message and frames it as
// PREFIX, source index, length (MSB first), payload and an 8-bit checksum.
module pkt_encoder #(
  parameter int unsigned N_SRC    = 8,
  parameter int unsigned LEN_W    = 8,
  parameter logic [7:0]  PREFIX   = 8'hA5,
  parameter int unsigned CHK_MODE = 0
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [N_SRC-1:0]       have_msg,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [LEN_W*N_SRC-1:0] len_bus,
  input  logic [8*N_SRC-1:0]     data_bus,
  output logic [N_SRC-1:0]       rdreq,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy
);

  localparam int unsigned SRC_W = $clog2(N_SRC);
  localparam int unsigned N_LB  = LEN_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_SRC, S_LEN, S_DATA, S_CHK} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d, last_q, last_d;
  logic [LEN_W-1:0]   len_q, len_d, pay_q, pay_d;
  logic               lb_q, lb_d;
  logic [7:0]         chk_q, chk_d, tx_data_d;
  logic               tx_valid_d, busy_d, pop;

  logic               grant_vld;
  logic [SRC_W-1:0]   grant_idx, arb_idx;
  logic [N_SRC-1:0]   req;
  logic [LEN_W-1:0]   grant_len;
  logic [7:0]         head;

  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return (CHK_MODE == 0) ? acc + b : acc ^ b;
  endfunction

  // idx 0 selects the high length byte when the field is two bytes wide
  function automatic logic [7:0] len_byte(input logic [LEN_W-1:0] len, input logic idx);
    return (N_LB > 1 && !idx) ? len[LEN_W-1 -: 8] : len[7:0];
  endfunction

  // Round robin: scan downward so the nearest index above last_q wins
  always_comb begin
    req       = have_msg & src_en;
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = '0;
    for (int unsigned k = N_SRC; k >= 1; k--) begin
      arb_idx = SRC_W'((32'(last_q) + k) % N_SRC);
      if (req[arb_idx]) begin
        grant_vld = 1'b1;
        grant_idx = arb_idx;
      end
    end
  end

  always_comb begin
    grant_len = '0;
    head      = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant_idx == SRC_W'(i)) grant_len = len_bus[LEN_W*i +: LEN_W];
      if (src_q == SRC_W'(i))     head      = data_bus[8*i +: 8];
    end
  end

  // Pop is combinational so the show-ahead head advances on the same edge it is captured
  assign rdreq = pop ? (N_SRC'(1) << src_q) : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      last_q   <= SRC_W'(N_SRC - 1);
      len_q    <= '0;
      pay_q    <= '0;
      lb_q     <= 1'b0;
      chk_q    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      last_q   <= last_d;
      len_q    <= len_d;
      pay_q    <= pay_d;
      lb_q     <= lb_d;
      chk_q    <= chk_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    last_d     = last_q;
    len_d      = len_q;
    pay_d      = pay_q;
    lb_d       = lb_q;
    chk_d      = chk_q;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: if (grant_vld) begin
        src_d      = grant_idx;
        last_d     = grant_idx;
        len_d      = grant_len;
        pay_d      = '0;
        lb_d       = 1'b0;
        chk_d      = '0;
        tx_data_d  = PREFIX;
        tx_valid_d = 1'b1;
        state_d    = S_PREFIX;
      end
      S_PREFIX: if (tx_ready) begin
        tx_data_d = 8'(src_q);
        chk_d     = chk_add(chk_q, 8'(src_q));
        state_d   = S_SRC;
      end
      S_SRC: if (tx_ready) begin
        tx_data_d = len_byte(len_q, 1'b0);
        chk_d     = chk_add(chk_q, len_byte(len_q, 1'b0));
        lb_d      = 1'b0;
        state_d   = S_LEN;
      end
      S_LEN: if (tx_ready) begin
        if (32'(lb_q) == N_LB - 1) begin
          if (len_q == '0) begin
            tx_data_d = chk_q;
            state_d   = S_CHK;
          end else begin
            tx_data_d = head;
            chk_d     = chk_add(chk_q, head);
            pay_d     = LEN_W'(1);
            pop       = 1'b1;
            state_d   = S_DATA;
          end
        end else begin
          lb_d      = 1'b1;
          tx_data_d = len_byte(len_q, 1'b1);
          chk_d     = chk_add(chk_q, len_byte(len_q, 1'b1));
        end
      end
      S_DATA: if (tx_ready) begin
        if (pay_q == len_q) begin
          tx_data_d = chk_q;
          state_d   = S_CHK;
        end else begin
          tx_data_d = head;
          chk_d     = chk_add(chk_q, head);
          pay_d     = pay_q + LEN_W'(1);
          pop       = 1'b1;
        end
      end
      S_CHK: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_pkt_encoder.sv
// Directed bench for pkt_encoder: additive, XOR and 16-bit-length instances with
// a show-ahead FIFO model per source; expected byte streams are hand computed.
module tb_pkt_encoder;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [7:0]   have_msg, src_en, have_msg2;
  logic [63:0]  len_bus;
  logic [127:0] len_bus2;
  logic [63:0]  data_bus, data_bus2;
  logic [7:0]   rdreq, rdreq1, rdreq2;
  logic [7:0]   tx_data, tx_data1, tx_data2;
  logic         tx_valid, tx_valid1, tx_valid2;
  logic         busy, busy1, busy2;
  logic         tx_ready;

  logic [7:0]   mem [8][16];
  int           pop_cnt [8] = '{default: 0};
  logic [7:0]   rx[$], rx1[$], rx2[$];
  logic         hold_pend = 1'b0;
  logic [7:0]   hold_data = 8'h00;
  logic         r2_seen = 1'b0;
  int           n_vec = 0, n_err = 0;
  int           base, c;

  always #5 clk = ~clk;

  pkt_encoder u_add (
    .clk(clk), .n_rst(n_rst), .have_msg(have_msg), .src_en(src_en), .len_bus(len_bus),
    .data_bus(data_bus), .rdreq(rdreq), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy));

  pkt_encoder #(.CHK_MODE(1)) u_xor (
    .clk(clk), .n_rst(n_rst), .have_msg(have_msg), .src_en(src_en), .len_bus(len_bus),
    .data_bus(data_bus), .rdreq(rdreq1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .busy(busy1));

  pkt_encoder #(.LEN_W(16)) u_l16 (
    .clk(clk), .n_rst(n_rst), .have_msg(have_msg2), .src_en(src_en), .len_bus(len_bus2),
    .data_bus(data_bus2), .rdreq(rdreq2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: head is the entry at the current pop count
  always_comb begin
    for (int i = 0; i < 8; i++) data_bus[8*i +: 8] = mem[i][4'(pop_cnt[i])];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (rdreq[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    if (tx_valid  && tx_ready) rx.push_back(tx_data);
    if (tx_valid1 && tx_ready) rx1.push_back(tx_data1);
    if (tx_valid2 && tx_ready) rx2.push_back(tx_data2);
    if (rdreq2 != 8'h00) r2_seen <= 1'b1;
    if (rdreq != 8'h00) check("rdreq_onehot", 32'($countones(rdreq)), 32'd1);
    if (hold_pend && n_rst) begin
      check("stall_data", 32'(tx_data), 32'(hold_data));
      check("stall_valid", 32'(tx_valid), 32'd1);
    end
    hold_pend <= n_rst && tx_valid && !tx_ready;
    hold_data <= tx_data;
  end

  task automatic load(input int s, input int len, input int n, input logic [63:0] bytes_be);
    logic [63:0] sh;
    len_bus = (len_bus & ~(64'hFF << (8*s))) | (64'(len) << (8*s));
    for (int k = 0; k < n; k++) begin
      sh = bytes_be >> (8*(n-1-k));
      mem[3'(s)][4'(pop_cnt[s] + k)] = sh[7:0];
    end
  endtask

  task automatic clr();
    rx.delete(); rx1.delete(); rx2.delete();
  endtask

  task automatic run_pkts(input int n, input bit toggle);
    int cyc = 0;
    while (rx.size() < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (toggle) tx_ready = ~tx_ready;
    end
    have_msg = 8'h00;
    tx_ready = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int which, input int n, input logic [191:0] exp_vec);
    int          got_n;
    logic [7:0]  g;
    logic [191:0] sh;
    got_n = (which == 0) ? rx.size() : (which == 1) ? rx1.size() : rx2.size();
    check({tag, "_count"}, 32'(got_n), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = 8'h00;
      if (i < got_n) g = (which == 0) ? rx[i] : (which == 1) ? rx1[i] : rx2[i];
      sh = exp_vec >> (8*(n-1-i));
      check(tag, 32'(g), 32'(sh[7:0]));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) for (int j = 0; j < 16; j++) mem[i][j] = 8'h00;
    n_rst = 1'b0; tx_ready = 1'b1; have_msg = 8'h00; have_msg2 = 8'h00;
    src_en = 8'hFF; len_bus = '0; len_bus2 = '0; data_bus2 = '0;
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_rdreq", 32'(rdreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid16", 32'(tx_valid2), 32'd0);
    check("rst_busy16", 32'(busy2), 32'd0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Alternating 0/7 from reset, then source 7 disabled
    clr();
    load(0, 1, 2, 64'h4041);
    load(7, 1, 2, 64'h7071);
    have_msg = 8'h81;
    run_pkts(20, 1'b0);
    check_seq("rr_alt", 0, 20, 192'({8'hA5, 8'h00, 8'h01, 8'h40, 8'h41, 8'hA5, 8'h07, 8'h01, 8'h70, 8'h78,
                                     8'hA5, 8'h00, 8'h01, 8'h41, 8'h42, 8'hA5, 8'h07, 8'h01, 8'h71, 8'h79}));
    clr();
    src_en = 8'h01;
    load(0, 1, 2, 64'h5051);
    have_msg = 8'h81;
    run_pkts(10, 1'b0);
    check_seq("rr_masked", 0, 10, 192'({8'hA5, 8'h00, 8'h01, 8'h50, 8'h51, 8'hA5, 8'h00, 8'h01, 8'h51, 8'h52}));
    check("src7_pops", 32'(pop_cnt[7]), 32'd2);
    src_en = 8'hFF;

    // Basic packet, both checksum modes, with one-cycle grant latency
    clr();
    base = pop_cnt[2];
    load(2, 3, 3, 64'h112233);
    @(negedge clk);
    have_msg = 8'h04;
    @(negedge clk);
    check("lat_valid", 32'(tx_valid), 32'd1);
    check("lat_prefix", 32'(tx_data), 32'hA5);
    check("lat_busy", 32'(busy), 32'd1);
    run_pkts(7, 1'b0);
    check_seq("pkt_add", 0, 7, 192'({8'hA5, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B}));
    check_seq("pkt_xor", 1, 7, 192'({8'hA5, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01}));
    check("src2_pops", 32'(pop_cnt[2] - base), 32'd3);
    @(negedge clk);
    check("idle_valid", 32'(tx_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Back-pressure toggling every cycle
    clr();
    base = pop_cnt[3];
    load(3, 4, 4, 64'h01020304);
    have_msg = 8'h08;
    run_pkts(8, 1'b1);
    check_seq("stall_pkt", 0, 8, 192'({8'hA5, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11}));
    check("src3_pops", 32'(pop_cnt[3] - base), 32'd4);

    // Reset in the middle of the payload
    @(negedge clk);
    base = pop_cnt[5];
    load(5, 5, 5, 64'h6162636465);
    have_msg = 8'h20;
    c = 0;
    while (pop_cnt[5] - base < 2 && c < 100) begin @(negedge clk); c++; end
    check("mid_pops", 32'(pop_cnt[5] - base), 32'd2);
    n_rst = 1'b0;
    have_msg = 8'h00;
    #1;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_rdreq", 32'(rdreq), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    check("mid_no_pop", 32'(pop_cnt[5] - base), 32'd2);
    clr();
    load(0, 1, 1, 64'h5A);
    have_msg = 8'h21;
    run_pkts(5, 1'b0);
    check_seq("post_rst", 0, 5, 192'({8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5B}));

    // 16-bit length field, zero-length payload
    clr();
    @(negedge clk);
    len_bus2 = '0;
    have_msg2 = 8'h02;
    c = 0;
    while (rx2.size() < 5 && c < 100) begin @(negedge clk); c++; end
    have_msg2 = 8'h00;
    check_seq("len16_zero", 2, 5, 192'({8'hA5, 8'h01, 8'h00, 8'h00, 8'h01}));
    check("len16_no_rdreq", 32'(r2_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_encoder.md
PKT_ENCODER -- requirements
Module: pkt_encoder

Interface
REQ-001 Parameter N_SRC, default 8: number of message sources, 2..64.
REQ-002 Parameter LEN_W, default 8: length-field width, 8 or 16 only.
REQ-003 Parameter PREFIX, default 8'hA5: packet start byte.
REQ-004 Parameter CHK_MODE, default 0: 0 = 8-bit additive checksum, 1 = 8-bit XOR checksum.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 have_msg  input  N_SRC  bit i high: source i holds a complete message.
REQ-008 src_en  input  N_SRC  bit i low: source i excluded from arbitration.
REQ-009 len_bus  input  LEN_W*N_SRC  slice i = payload byte count of source i, stable while have_msg[i] is high.
REQ-010 data_bus  input  8*N_SRC  slice i = show-ahead FIFO head of source i.
REQ-011 rdreq  output  N_SRC  one-hot pop strobe to the served source.
REQ-012 tx_data  output  8  outgoing byte.
REQ-013 tx_valid  output  1  tx_data valid.
REQ-014 tx_ready  input  1  sink accepts the byte.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 A byte transfers on any cycle where tx_valid and tx_ready are both high; tx_data and tx_valid are registered and stay stable until that transfer.
REQ-017 Packet format: PREFIX, source index (8 bits, zero-extended), length (LEN_W/8 bytes, MSB first), payload bytes, checksum.
REQ-018 States: IDLE, PREFIX, SRC, LEN, DATA, CHK; each non-IDLE state advances only on a transfer.
REQ-019 IDLE: request set = have_msg & src_en; a non-empty set grants, round-robin, the lowest index above the last-served source, wrapping to 0; the first grant after reset searches from index 0.
REQ-020 Grant latches the source index and its length; next cycle tx_data=PREFIX, tx_valid=1, state PREFIX (one-cycle latency from request to tx_valid).
REQ-021 PREFIX -> SRC -> LEN: each transfer loads the next header byte; LEN uses a byte counter for the LEN_W/8 length bytes.
REQ-022 After the last length byte: length 0 goes straight to CHK; otherwise to DATA with tx_data = data_bus slice of the granted source.
REQ-023 In DATA, each loaded payload byte pulses rdreq for exactly one cycle, in the same cycle it is captured into tx_data; total rdreq pulses per packet = length.
REQ-024 The payload counter is LEN_W bits wide; DATA -> CHK when the transfer of byte number length occurs.
REQ-025 Checksum covers the source byte, all length bytes and all payload bytes, modulo 256 (CHK_MODE 0) or XOR (CHK_MODE 1), initialised to 0 at grant.
REQ-026 CHK transfer -> IDLE, tx_valid=0 the next cycle; the next arbitration takes place in IDLE on that cycle, so packets are separated by one idle cycle.
REQ-027 have_msg or src_en changes after grant do not affect the packet in progress.
REQ-028 tx_ready low in any state holds all registers; no rdreq pulse is issued while stalled.

Reset
REQ-029 On n_rst low, asynchronously: state IDLE, tx_data 0, tx_valid 0, rdreq 0, busy 0, counters 0, checksum 0, last-served pointer = N_SRC-1.
REQ-030 Reset mid-packet abandons the packet without a checksum; sources are not popped further, and FIFO recovery is upstream's responsibility.
REQ-031 Deassertion of n_rst is synchronised to clk by the integrator; the block needs no extra cycles.

Verification
REQ-032 N_SRC=8, LEN_W=8, tx_ready=1, have_msg=8'h04, len 3, data 11,22,33 -> bytes A5,02,03,11,22,33,6B; exactly 3 rdreq[2] pulses.
REQ-033 Same stimulus with CHK_MODE=1 -> checksum byte 02^03^11^22^33 = 01.
REQ-034 LEN_W=16, source 1, length 16'h0000 -> A5,01,00,00,01; no rdreq.
REQ-035 have_msg=8'h81 held continuously -> grants alternate 0,7,0,7; src_en[7]=0 -> only source 0 is served.
REQ-036 tx_ready toggling 1/0 every cycle across a 4-byte packet -> byte sequence identical to tx_ready=1, tx_data stable while stalled, no duplicate rdreq.
REQ-037 n_rst pulsed during DATA -> all outputs 0 immediately; the next packet starts with PREFIX and arbitration from source 0.
